// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter.
package alu_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned NumReq    = 2;

  // ALU op codes; any other 3-bit code yields a zero result.
  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011
  } alu_op_e;

  // Identifies one of the two requesters.
  typedef logic req_id_t;

  // Arbiter FSM: idle, or holding a result for its owner.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage : alu_pkg

// File: rtl/alu.sv
// Combinational 32-bit ALU: add, subtract, and, or; unknown op codes give zero.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]           alu_ctrl,
  input  logic [DataWidth-1:0] src1,
  input  logic [DataWidth-1:0] src2,
  output logic [DataWidth-1:0] alu_res,
  output logic                 zero
);

  // Result select; add and subtract wrap modulo 2^32 with no carry out.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OpAdd:   alu_res = src1 + src2;
      OpSub:   alu_res = src1 + (~src2 + 32'd1);
      OpAnd:   alu_res = src1 & src2;
      OpOr:    alu_res = src1 | src2;
      default: alu_res = '0;
    endcase
  end

  // Zero flag of the current result.
  always_comb begin
    zero = (alu_res == '0);
  end

endmodule : alu

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. A granted request is computed in the
// accept cycle and its result is held registered until the owner takes it.
// The response handshake and a new accept may coincide for one op per cycle.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NumReq-1:0]               req_valid,
  output logic [NumReq-1:0]               req_ready,
  input  logic [NumReq-1:0][2:0]          req_ctrl,
  input  logic [NumReq-1:0][DataWidth-1:0] req_src1,
  input  logic [NumReq-1:0][DataWidth-1:0] req_src2,
  output logic [NumReq-1:0]               rsp_valid,
  input  logic [NumReq-1:0]               rsp_ready,
  output logic [DataWidth-1:0]            rsp_res,
  output logic                            rsp_zero
);

  arb_state_e           state_q, state_d;
  req_id_t              prio_q, prio_d;
  req_id_t              owner_q, owner_d;
  logic [DataWidth-1:0] res_q, res_d;
  logic                 zero_q, zero_d;

  req_id_t              gnt;
  logic                 slot_free;
  logic                 accept;
  logic [2:0]           alu_ctrl;
  logic [DataWidth-1:0] alu_src1;
  logic [DataWidth-1:0] alu_src2;
  logic [DataWidth-1:0] alu_res;
  logic                 alu_zero;

  // Grant: a lone requester wins; on contention the priority pointer decides.
  always_comb begin
    gnt = prio_q;
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = prio_q;
    endcase
  end

  // The result slot can take a new op when empty or being drained this cycle.
  // Only the owner's rsp_ready matters, so a stray rsp_ready is harmless.
  always_comb begin
    slot_free = (state_q == StIdle) || rsp_ready[owner_q];
  end

  // Accept only to the granted requester; held off entirely during reset.
  always_comb begin
    req_ready = '0;
    if (!rst && slot_free && req_valid[gnt]) begin
      req_ready[gnt] = 1'b1;
    end
  end

  // Accept handshake of the granted requester.
  always_comb begin
    accept = |(req_valid & req_ready);
  end

  // Route the granted requester's operands into the shared ALU.
  always_comb begin
    alu_ctrl = req_ctrl[gnt];
    alu_src1 = req_src1[gnt];
    alu_src2 = req_src2[gnt];
  end

  alu u_alu (
    .alu_ctrl (alu_ctrl),
    .src1     (alu_src1),
    .src2     (alu_src2),
    .alu_res  (alu_res),
    .zero     (alu_zero)
  );

  // Next-state: load on accept, go idle on a bare response handshake, else hold.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          owner_d = gnt;
          prio_d  = ~gnt;
          res_d   = alu_res;
          zero_d  = alu_zero;
        end
      end
      StBusy: begin
        if (accept) begin
          owner_d = gnt;
          prio_d  = ~gnt;
          res_d   = alu_res;
          zero_d  = alu_zero;
        end else if (rsp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any held result without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Response outputs decode straight from registered state.
  always_comb begin
    rsp_valid = '0;
    if (state_q == StBusy) begin
      rsp_valid[owner_q] = 1'b1;
    end
    rsp_res  = res_q;
    rsp_zero = zero_q;
  end

endmodule : alu_arbiter

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and requester count at 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  [1:0]  per-requester operation request.
REQ-005 req_ready  output  [1:0]  per-requester accept; at most one bit high per cycle.
REQ-006 req_ctrl  input  [1:0][2:0]  per-requester ALU op code (ADD 000, SUB 001, AND 010, OR 011, others give result 0).
REQ-007 req_src1  input  [1:0][31:0]  per-requester operand 1.
REQ-008 req_src2  input  [1:0][31:0]  per-requester operand 2.
REQ-009 rsp_valid  output  [1:0]  per-requester result valid; at most one bit high per cycle.
REQ-010 rsp_ready  input  [1:0]  per-requester result accept.
REQ-011 rsp_res  output  32  registered result, shared by both requesters.
REQ-012 rsp_zero  output  1  registered flag, rsp_res == 0.

Function
REQ-013 Block SHALL share one ALU instance between two requesters; state machine states IDLE and BUSY.
REQ-014 Grant: pointer prio (1 bit); if only one req_valid bit set, grant it; if both set, grant prio.
REQ-015 req_ready[g] SHALL be high only for granted g, and only when state==IDLE or (state==BUSY and rsp_ready[owner]==1); combinational, no dependency on rsp_ready of the non-owner.
REQ-016 Accept handshake = req_valid[g] & req_ready[g]; on accept, ALU result of granted operands SHALL be captured into rsp_res/rsp_zero, owner<=g, state<=BUSY, prio<=~g.
REQ-017 Latency: result visible with rsp_valid[owner]=1 in cycle after accept (1 cycle).
REQ-018 BUSY: rsp_valid[owner]=1, rsp_res/rsp_zero/owner held stable until rsp_ready[owner]==1.
REQ-019 Response handshake without simultaneous accept: state<=IDLE, rsp_valid<=0 next cycle.
REQ-020 Response handshake with simultaneous accept (back-to-back): state stays BUSY, new result/owner loaded; sustained throughput one op per cycle.
REQ-021 prio SHALL change only on accept; no accept leaves prio unchanged.
REQ-022 SUB SHALL compute src1 + (~src2 + 1) modulo 2^32; ADD wraps modulo 2^32; no overflow/carry output.
REQ-023 req_* inputs of a non-granted requester SHALL be ignored; its request remains pending (no drop).
REQ-024 rsp_ready of a requester with rsp_valid low SHALL have no effect.

Reset
REQ-025 On rst=1 at clock edge: state<=IDLE, prio<=0, owner<=0, rsp_valid<=0, rsp_res<=0, rsp_zero<=1.
REQ-026 While rst=1, req_ready SHALL be 0; reset mid-operation SHALL discard any held result without a response handshake.

Structure
REQ-027 Shared package alu_pkg SHALL hold ALU op-code constants/enum (ADD, SUB, AND, OR) and requester-id typedef (1 bit).
REQ-028 ALU SHALL be one instance of the existing sub-module alu (alu_ctrl, src1, src2, alu_res, zero); no duplicate arithmetic in alu_arbiter.
REQ-029 Grant logic and FSM in alu_arbiter itself; no further sub-modules.

Verification
REQ-030 After reset, req_valid=01, ctrl ADD, src1=5, src2=7 -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_res=12, rsp_zero=0.
REQ-031 Both valid after reset: r0 SUB 3-3, r1 OR 0xF0|0x0F -> r0 granted first (rsp_res=0, rsp_zero=1), then r1 (rsp_res=0xFF); prio alternates.
REQ-032 Backpressure: rsp_ready[owner]=0 for 3 cycles -> rsp_valid, rsp_res stable, req_ready=00; on rsp_ready=1 handshake completes.
REQ-033 Back-to-back: rsp_ready held 1, both requesters valid continuously -> one result per cycle, owners alternating 0,1,0,1.
REQ-034 Wrap: ADD 0xFFFFFFFF+1 -> rsp_res=0, rsp_zero=1; SUB 0-1 -> 0xFFFFFFFF; ctrl 111 -> rsp_res=0.
REQ-035 Reset asserted while BUSY -> next cycle rsp_valid=00, rsp_res=0, rsp_zero=1, prio=0.
